// File: rtl/fma16_pkg.sv
// Shared types and constants for the fma16 issue/retire stage.
// Control, flag and FIFO-entry layouts live here so every file agrees on them.
package fma16_pkg;

    typedef struct packed {
        logic [1:0] rsvd;
        logic [1:0] rm;
        logic       mul;
        logic       add;
        logic       negp;
        logic       negz;
    } fma16_ctrl_t;

    typedef struct packed {
        logic inv;
        logic ovf;
        logic unf;
        logic inx;
    } fma16_flags_t;

    typedef struct packed {
        logic [15:0]  result;
        fma16_flags_t flags;
    } fma16_res_t;

    localparam logic [7:0]  CTRL_RSVD_MASK = 8'hc0;
    localparam logic [15:0] QNAN16         = 16'h7e00;
    localparam logic [3:0]  FLAG_INV       = 4'b1000;

    typedef enum logic {
        IDLE,
        EXEC
    } issue_state_t;

    function automatic logic ctrl_illegal(input logic [7:0] c);
        return |(c & CTRL_RSVD_MASK);
    endfunction

endpackage

// File: rtl/fma16_rfifo.sv
// Circular result FIFO with wrapping read/write pointers and an occupancy count.
// Storage is not reset; only pointers and count are, which empties the buffer.
module fma16_rfifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 20,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fma16_issue.sv
// Issue/retire stage around the combinational fma16 datapath: hold operands
// for LAT cycles, capture result/flags into a FIFO, keep sticky flags.
module fma16_issue
    import fma16_pkg::*;
#(
    parameter int LAT    = 1,
    parameter int RDEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    input  logic [15:0] in_y,
    input  logic [15:0] in_z,
    input  logic [7:0]  in_ctrl,
    output logic [15:0] fma_x,
    output logic [15:0] fma_y,
    output logic [15:0] fma_z,
    output logic        fma_mul,
    output logic        fma_add,
    output logic        fma_negp,
    output logic        fma_negz,
    output logic [1:0]  fma_rm,
    input  logic [15:0] fma_result,
    input  logic [3:0]  fma_flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic [3:0]  out_flags,
    output logic [3:0]  flags_sticky,
    input  logic        flags_clr,
    output logic [31:0] op_count
);

    localparam int CW = $clog2(RDEPTH) + 1;

    issue_state_t state;
    issue_state_t state_nxt;
    fma16_ctrl_t  c;
    fma16_res_t   pdata;
    fma16_res_t   rdata;
    logic [3:0]   cnt;
    logic         illegal_q;
    logic         accept;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    logic [CW-1:0] fcount;

    assign c      = fma16_ctrl_t'(in_ctrl);
    assign accept = in_valid && in_ready;

    // Illegal ops retire a canonical qNaN with only the invalid flag set.
    assign pdata = illegal_q ? fma16_res_t'({QNAN16, FLAG_INV})
                             : fma16_res_t'({fma_result, fma_flags});

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    if (cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Only one op is ever in flight, so a free slot at accept is a reservation.
    always_comb begin
        in_ready = 1'b0;
        push     = 1'b0;
        if (reset_n) begin
            unique case (state)
                IDLE:    in_ready = !full;
                EXEC:    push = (cnt == 4'd0);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt       <= '0;
            illegal_q <= 1'b0;
            fma_x     <= '0;
            fma_y     <= '0;
            fma_z     <= '0;
            fma_mul   <= 1'b0;
            fma_add   <= 1'b0;
            fma_negp  <= 1'b0;
            fma_negz  <= 1'b0;
            fma_rm    <= '0;
        end else if (accept) begin
            cnt       <= 4'(LAT - 1);
            illegal_q <= ctrl_illegal(in_ctrl);
            if (c.rsvd == 2'b00) begin
                fma_x    <= in_x;
                fma_y    <= in_y;
                fma_z    <= in_z;
                fma_mul  <= c.mul;
                fma_add  <= c.add;
                fma_negp <= c.negp;
                fma_negz <= c.negz;
                fma_rm   <= c.rm;
            end
        end else if (state == EXEC && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Clear comes before the OR so flags retired in a clear cycle survive.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_sticky <= '0;
            op_count     <= '0;
        end else if (push) begin
            flags_sticky <= (flags_clr ? 4'b0000 : flags_sticky) | pdata.flags;
            op_count     <= op_count + 32'd1;
        end else if (flags_clr) begin
            flags_sticky <= '0;
        end
    end

    assign pop        = out_ready && !empty;
    assign out_valid  = (fcount != '0);
    assign out_result = rdata.result;
    assign out_flags  = rdata.flags;

    fma16_rfifo #(
        .DEPTH (RDEPTH),
        .WIDTH (20)
    ) u_rfifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (pdata),
        .pop     (pop),
        .rdata   (rdata),
        .full    (full),
        .empty   (empty),
        .count   (fcount)
    );

endmodule

// File: tb/tb_fma16_issue.sv
// Directed bench for fma16_issue with a table-driven fma16 stand-in
// and a result scoreboard checked whenever the FIFO head is consumed.
module tb_fma16_issue;

    localparam int LAT    = 4;
    localparam int RDEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x, in_y, in_z;
    logic [7:0]  in_ctrl;
    logic [15:0] fma_x, fma_y, fma_z;
    logic        fma_mul, fma_add, fma_negp, fma_negz;
    logic [1:0]  fma_rm;
    logic [15:0] fma_result;
    logic [3:0]  fma_flags;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_flags;
    logic [3:0]  flags_sticky;
    logic        flags_clr;
    logic [31:0] op_count;

    int tests = 0;
    int fails = 0;
    int bp_mode = 0;
    logic [19:0] sbq[$];

    always #5 clk = ~clk;

    fma16_issue #(
        .LAT    (LAT),
        .RDEPTH (RDEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_z         (in_z),
        .in_ctrl      (in_ctrl),
        .fma_x        (fma_x),
        .fma_y        (fma_y),
        .fma_z        (fma_z),
        .fma_mul      (fma_mul),
        .fma_add      (fma_add),
        .fma_negp     (fma_negp),
        .fma_negz     (fma_negz),
        .fma_rm       (fma_rm),
        .fma_result   (fma_result),
        .fma_flags    (fma_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .flags_sticky (flags_sticky),
        .flags_clr    (flags_clr),
        .op_count     (op_count)
    );

    // fma16 stand-in: exact half-precision results for the directed operands.
    function automatic logic [19:0] fma_model(
        input logic [15:0] x, y, z,
        input logic mul, add, negp, negz,
        input logic [1:0] rm
    );
        if (rm != 2'b00 || !mul)
            return {x ^ y ^ z, 4'b0000};
        if (!add && x == 16'h3c00 && y == 16'h4000)
            return {16'h4000, 4'b0000};
        if (!add && x == 16'h3c01 && y == 16'h3c01)
            return {16'h3c02, 4'b0001};
        if (add && !negz && x == 16'h3c00 && y == 16'h4000 && z == 16'h3e00)
            return negp ? {16'hb800, 4'b0000} : {16'h4300, 4'b0000};
        return {x ^ y ^ z, 4'b0000};
    endfunction

    always_comb begin
        {fma_result, fma_flags} = fma_model(fma_x, fma_y, fma_z, fma_mul,
                                            fma_add, fma_negp, fma_negz, fma_rm);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives out_ready for the next edge, then scores the head that edge consumes.
    always @(negedge clk) begin
        logic [19:0] e;
        case (bp_mode)
            0:       out_ready = 1'b1;
            2:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (reset_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected", 32'(out_valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                check("sb_result", 32'(out_result), 32'(e[19:4]));
                check("sb_flags", 32'(out_flags), 32'(e[3:0]));
            end
        end
    end

    task automatic send(input logic [15:0] x, y, z, input logic [7:0] ctrl,
                        input logic [19:0] exp);
        int n;
        in_x = x;
        in_y = y;
        in_z = z;
        in_ctrl = ctrl;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            tick(1);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clk);
            sbq.push_back(exp);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (sbq.size() != 0 || out_valid); i++)
            tick(1);
        check("drain", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_x = '0;
        in_y = '0;
        in_z = '0;
        in_ctrl = '0;
        flags_clr = 1'b0;
        bp_mode = 0;

        tick(2);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        reset_n = 1'b1;
        check("rst_op_count", op_count, 32'd0);
        check("rst_sticky", 32'(flags_sticky), 32'd0);
        check("rst_fma_x", 32'(fma_x), 32'd0);
        check("rst_fma_mul", 32'(fma_mul), 32'd0);
        tick(1);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Multiply, latency exactly LAT edges after accept.
        send(16'h3c00, 16'h4000, 16'h0000, 8'h08, {16'h4000, 4'h0});
        check("t1_exec_in_ready", 32'(in_ready), 32'd0);
        for (int k = 1; k < LAT; k++) begin
            tick(1);
            check("t1_early", 32'(out_valid), 32'd0);
        end
        tick(1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_result", 32'(out_result), 32'h4000);
        check("t1_fma_mul", 32'(fma_mul), 32'd1);
        check("t1_fma_add", 32'(fma_add), 32'd0);
        drain();
        check("t1_op_count", op_count, 32'd1);

        // FMA, then with negated product: 2+1.5 and -2+1.5.
        send(16'h3c00, 16'h4000, 16'h3e00, 8'h0c, {16'h4300, 4'h0});
        drain();
        send(16'h3c00, 16'h4000, 16'h3e00, 8'h0e, {16'hb800, 4'h0});
        drain();
        check("t2_op_count", op_count, 32'd3);

        // Illegal ctrl leaves the previous operands on fma_*.
        send(16'h1234, 16'h5678, 16'h1111, 8'h48, {16'h7e00, 4'b1000});
        check("t4_fma_x", 32'(fma_x), 32'h3c00);
        check("t4_fma_z", 32'(fma_z), 32'h3e00);
        check("t4_fma_negp", 32'(fma_negp), 32'd1);
        drain();
        check("t4_sticky", 32'(flags_sticky), 32'b1000);
        check("t4_fma_y", 32'(fma_y), 32'h4000);
        check("t4_op_count", op_count, 32'd4);

        // Clear coinciding with a push keeps the pushed flags.
        send(16'h3c01, 16'h3c01, 16'h0000, 8'h08, {16'h3c02, 4'b0001});
        check("t5_fma_x", 32'(fma_x), 32'h3c01);
        check("t5_fma_negp", 32'(fma_negp), 32'd0);
        tick(LAT - 1);
        flags_clr = 1'b1;
        tick(1);
        flags_clr = 1'b0;
        check("t5_sticky_push_clr", 32'(flags_sticky), 32'b0001);
        flags_clr = 1'b1;
        tick(1);
        flags_clr = 1'b0;
        check("t5_sticky_clr", 32'(flags_sticky), 32'b0000);
        drain();

        // Back-pressure: fill the FIFO, one pop reopens the input.
        bp_mode = 2;
        send(16'h3c00, 16'h4000, 16'h0000, 8'h08, {16'h4000, 4'h0});
        send(16'h3c00, 16'h4000, 16'h3e00, 8'h0c, {16'h4300, 4'h0});
        tick(LAT);
        check("t3_full_in_ready", 32'(in_ready), 32'd0);
        check("t3_full_out_valid", 32'(out_valid), 32'd1);
        tick(2);
        check("t3_held_in_ready", 32'(in_ready), 32'd0);
        bp_mode = 0;
        tick(1);
        bp_mode = 2;
        check("t3_pop_in_ready", 32'(in_ready), 32'd1);
        tick(1);
        check("t3_one_left", 32'(out_valid), 32'd1);
        check("t3_op_count", op_count, 32'd7);

        // Random back-pressure with a run of ops, scored in order.
        bp_mode = 1;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] xv;
            xv = 16'h1000 + 16'(i);
            send(xv, 16'h0002, 16'h0005, 8'h08,
                 {xv ^ 16'h0002 ^ 16'h0005, 4'b0000});
        end
        drain();
        check("rand_op_count", op_count, 32'd11);

        // Reset in the middle of EXEC discards the op.
        bp_mode = 0;
        send(16'h3c00, 16'h4000, 16'h0000, 8'h08, {16'h4000, 4'h0});
        tick(1);
        reset_n = 1'b0;
        check("t6_rst_in_ready", 32'(in_ready), 32'd0);
        void'(sbq.pop_back());
        tick(1);
        reset_n = 1'b1;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_op_count", op_count, 32'd0);
        check("t6_fma_x", 32'(fma_x), 32'd0);
        tick(LAT + 2);
        check("t6_no_push", 32'(out_valid), 32'd0);
        check("t6_op_count_late", op_count, 32'd0);
        send(16'h3c00, 16'h4000, 16'h3e00, 8'h0c, {16'h4300, 4'h0});
        drain();
        check("t6_after_op_count", op_count, 32'd1);
        check("t6_sticky", 32'(flags_sticky), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
